// File: rtl/mem_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_load_ctrl
//  Description : Command-driven loader for external IRAM/DRAM. Streams words
//                into a memory window, reads a DRAM window back out as a
//                stream, or holds the processor run enable for a fixed time.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_load_ctrl #(
    parameter int WR_PULSE   = 4,
    parameter int RD_LAT     = 5,
    parameter int RUN_CYCLES = 120000
) (
    input  logic        clock,
    input  logic        reset_n,
    // command channel
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [8:0]  cmd_lo,
    input  logic [8:0]  cmd_hi,
    // load-word stream
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    // readback-word stream
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    // mode enables
    output logic        start,
    output logic        start_2,
    output logic        start_3,
    output logic        start_4,
    // external memory side
    output logic [8:0]  addr_ext,
    output logic        iram_write_ext,
    output logic        dram_write_ext,
    output logic        read_en_ext,
    output logic [15:0] Data_in_ins,
    output logic [15:0] Data_in_dram,
    input  logic [15:0] dram_in,
    // status
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] c_OP_IRAM = 2'b00;
    localparam logic [1:0] c_OP_DRAM = 2'b01;
    localparam logic [1:0] c_OP_READ = 2'b10;
    localparam logic [1:0] c_OP_RUN  = 2'b11;

    localparam logic [3:0] c_IDLE      = 4'd0;
    localparam logic [3:0] c_SETUP     = 4'd1;
    localparam logic [3:0] c_WAIT_DATA = 4'd2;
    localparam logic [3:0] c_WRITE     = 4'd3;
    localparam logic [3:0] c_WGAP      = 4'd4;
    localparam logic [3:0] c_RD_REQ    = 4'd5;
    localparam logic [3:0] c_RD_WAIT   = 4'd6;
    localparam logic [3:0] c_RD_OUT    = 4'd7;
    localparam logic [3:0] c_RUN       = 4'd8;
    localparam logic [3:0] c_FINISH    = 4'd9;

    localparam logic [31:0] c_WR_LAST  = 32'(WR_PULSE - 1);
    localparam logic [31:0] c_RD_LAST  = 32'(RD_LAT - 1);
    localparam logic [31:0] c_RUN_LAST = 32'(RUN_CYCLES - 1);

    logic [3:0]  r_state;
    logic [1:0]  r_op;
    logic [8:0]  r_hi;
    logic [8:0]  r_addr;
    logic [31:0] r_cnt;
    logic [15:0] r_ins;
    logic [15:0] r_dram;
    logic [15:0] r_out;

    logic [8:0]  w_addr_inc;
    logic        w_mode_active;
    logic        w_write;
    logic        w_in_hs;

    assign w_addr_inc    = r_addr + 9'd1;
    // Load/readback enables cover SETUP through FINISH; RUN owns only `start`.
    assign w_mode_active = (r_state != c_IDLE) && (r_state != c_RUN);
    assign w_write       = (r_state == c_WRITE);
    assign w_in_hs       = (r_state == c_WAIT_DATA) && in_valid;

    // Control state, address window walk and shared cycle counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
            r_op    <= c_OP_IRAM;
            r_hi    <= 9'd0;
            r_addr  <= 9'd0;
            r_cnt   <= 32'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (cmd_valid) begin
                        r_op  <= cmd_op;
                        r_hi  <= cmd_hi;
                        r_cnt <= 32'd0;
                        if (cmd_op == c_OP_RUN) begin
                            r_state <= c_RUN;
                        end else begin
                            r_addr  <= cmd_lo;
                            r_state <= c_SETUP;
                        end
                    end
                end
                c_SETUP: begin
                    if (r_addr >= r_hi) begin
                        r_state <= c_FINISH;
                    end else if (r_op == c_OP_READ) begin
                        r_state <= c_RD_REQ;
                    end else begin
                        r_state <= c_WAIT_DATA;
                    end
                end
                c_WAIT_DATA: begin
                    if (in_valid) begin
                        r_cnt   <= 32'd0;
                        r_state <= c_WRITE;
                    end
                end
                c_WRITE: begin
                    if (r_cnt == c_WR_LAST) begin
                        r_cnt   <= 32'd0;
                        r_state <= c_WGAP;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                c_WGAP: begin
                    // Address moves only here, while the strobe is low.
                    r_addr  <= w_addr_inc;
                    r_state <= (w_addr_inc == r_hi) ? c_FINISH : c_WAIT_DATA;
                end
                c_RD_REQ: begin
                    r_cnt   <= 32'd0;
                    r_state <= c_RD_WAIT;
                end
                c_RD_WAIT: begin
                    if (r_cnt == c_RD_LAST) begin
                        r_cnt   <= 32'd0;
                        r_state <= c_RD_OUT;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                c_RD_OUT: begin
                    if (out_ready) begin
                        r_addr  <= w_addr_inc;
                        r_state <= (w_addr_inc == r_hi) ? c_FINISH : c_RD_REQ;
                    end
                end
                c_RUN: begin
                    if (r_cnt == c_RUN_LAST) begin
                        r_cnt   <= 32'd0;
                        r_state <= c_FINISH;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                c_FINISH: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Data registers: load words on stream handshake, readback word at end of read latency.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ins  <= 16'd0;
            r_dram <= 16'd0;
            r_out  <= 16'd0;
        end else begin
            if (w_in_hs && (r_op == c_OP_IRAM)) begin
                r_ins <= in_data;
            end
            if (w_in_hs && (r_op == c_OP_DRAM)) begin
                r_dram <= in_data;
            end
            if ((r_state == c_RD_WAIT) && (r_cnt == c_RD_LAST)) begin
                r_out <= dram_in;
            end
        end
    end

    assign cmd_ready      = (r_state == c_IDLE);
    assign busy           = (r_state != c_IDLE);
    assign in_ready       = (r_state == c_WAIT_DATA);
    assign out_valid      = (r_state == c_RD_OUT);
    assign out_data       = r_out;
    assign done           = (r_state == c_FINISH);

    assign start          = (r_state == c_RUN);
    assign start_2        = w_mode_active && (r_op == c_OP_IRAM);
    assign start_3        = w_mode_active && (r_op == c_OP_DRAM);
    assign start_4        = w_mode_active && (r_op == c_OP_READ);

    assign addr_ext       = r_addr;
    assign iram_write_ext = w_write && (r_op == c_OP_IRAM);
    assign dram_write_ext = w_write && (r_op == c_OP_DRAM);
    // Read strobe starts the cycle after RD_REQ so it never overlaps an address change.
    assign read_en_ext    = (r_state == c_RD_WAIT);
    assign Data_in_ins    = r_ins;
    assign Data_in_dram   = r_dram;

endmodule
`default_nettype wire
